symbol_framer: RTL and testbench

Upstream feeder for the 4-tone carrier generator. Accepts payload bytes over a valid/ready handshake and wraps them in a frame: preamble, sync word, payload, then guard. Serialises the frame MSB-first into 2-bit symbols, holding each symbol for a fixed number of clocks. Drives the carrier's VALUE and ENABLE inputs directly.

---
 rtl/symbol_framer_pkg.sv | 29 ++
 rtl/symbol_framer_if.sv | 15 +
 rtl/symbol_framer_timer.sv | 33 +++
 rtl/symbol_framer.sv | 182 ++++++++++++++++++
 tb/tb_symbol_framer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/symbol_framer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// framer_pkg : state encoding and frame constants for symbol_framer
// Rev 1.0
// ----------------------------------------------------------------------------
package framer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SYNC     = 3'd2,
    PAYLOAD  = 3'd3,
    GUARD    = 3'd4
  } state_t;

  localparam logic [1:0] PREAMBLE_HI      = 2'd3;
  localparam logic [1:0] PREAMBLE_LO      = 2'd0;
  localparam int         SYMBOLS_PER_BYTE = 4;
  localparam int         SYNC_SYMBOLS     = 8;

  // Symbol idx of the sync word, counted MSB-first.
  function automatic logic [1:0] sync_symbol(input logic [15:0] word, input logic [2:0] idx);
    logic [15:0] sh;
    sh = word << {idx, 1'b0};
    return sh[15:14];
  endfunction

endpackage
`default_nettype wire

// File: rtl/symbol_framer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// symbol_framer_if : payload byte stream (valid/ready with LAST qualifier)
// Rev 1.0
// ----------------------------------------------------------------------------
interface symbol_framer_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/symbol_framer_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// symbol_timer : down-counter producing one strobe per symbol period
// Rev 1.0
// ----------------------------------------------------------------------------
module symbol_timer #(
  parameter int SYMBOL_CYCLES = 100
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic restart_i,
  output logic      sym_strobe_o
);

  localparam int            CW     = (SYMBOL_CYCLES > 2) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SYMBOL_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RELOAD;
    end else if (restart_i || (count_q == '0)) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_q - CW'(1);
    end
  end

  assign sym_strobe_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/symbol_framer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// symbol_framer : wraps payload bytes in preamble/sync/guard, 2-bit symbols out
// Rev 1.0
// ----------------------------------------------------------------------------
module symbol_framer
  import framer_pkg::*;
#(
  parameter int          CLOCK_FREQUENCY  = 100000000,
  parameter int          SYMBOL_RATE      = 1000000,
  parameter int          PREAMBLE_SYMBOLS = 16,
  parameter logic [15:0] SYNC_WORD        = 16'hD391,
  parameter int          GUARD_SYMBOLS    = 4
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  symbol_framer_if.slave in_if,
  output logic [1:0]     value_o,
  output logic           enable_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           underrun_o
);

  localparam int          SYMBOL_CYCLES = CLOCK_FREQUENCY / SYMBOL_RATE;
  localparam logic [15:0] PRE_LAST      = 16'(PREAMBLE_SYMBOLS - 1);
  localparam logic [15:0] SYNC_LAST     = 16'(SYNC_SYMBOLS - 1);
  localparam logic [15:0] BYTE_LAST     = 16'(SYMBOLS_PER_BYTE - 1);
  localparam logic [15:0] GUARD_LAST    = 16'(GUARD_SYMBOLS - 1);

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  shift_q, shift_d, hold_q, hold_d;
  logic        shift_last_q, shift_last_d, hold_last_q, hold_last_d;
  logic        hold_full_q, hold_full_d, last_seen_q, last_seen_d;
  logic [1:0]  value_q, value_d;
  logic        enable_q, enable_d, busy_q, busy_d, done_q, done_d;
  logic        underrun_q, underrun_d, ready_q, ready_d;
  logic        restart, sym_strobe, transfer;

  symbol_timer #(.SYMBOL_CYCLES(SYMBOL_CYCLES)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart_i    (restart),
    .sym_strobe_o (sym_strobe)
  );

  assign transfer = ready_q && in_if.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      last_seen_q  <= 1'b0;
      value_q      <= 2'd0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      last_seen_q  <= last_seen_d;
      value_q      <= value_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    last_seen_d  = last_seen_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    restart      = 1'b0;

    case (state_q)
      // A byte left in holding by a late transfer also starts a frame.
      IDLE: if (transfer || hold_full_q) begin
        state_d = PREAMBLE;
        idx_d   = '0;
        restart = 1'b1;
      end
      PREAMBLE: if (sym_strobe) begin
        if (idx_q == PRE_LAST) begin
          state_d = SYNC;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      SYNC: if (sym_strobe) begin
        if (idx_q == SYNC_LAST) begin
          state_d      = PAYLOAD;
          idx_d        = '0;
          shift_d      = hold_q;
          shift_last_d = hold_last_q;
          hold_full_d  = 1'b0;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      PAYLOAD: if (sym_strobe) begin
        if (idx_q != BYTE_LAST) begin
          idx_d   = idx_q + 16'd1;
          shift_d = {shift_q[5:0], 2'b00};
        end else if (shift_last_q) begin
          state_d = GUARD;
          idx_d   = '0;
        end else if (hold_full_q) begin
          idx_d        = '0;
          shift_d      = hold_q;
          shift_last_d = hold_last_q;
          hold_full_d  = 1'b0;
        end else begin
          underrun_d = 1'b1;
          state_d    = GUARD;
          idx_d      = '0;
        end
      end
      GUARD: if (sym_strobe) begin
        if (idx_q == GUARD_LAST) begin
          state_d     = IDLE;
          idx_d       = '0;
          done_d      = 1'b1;
          last_seen_d = 1'b0;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied after draining so a simultaneous load keeps holding full.
    if (transfer) begin
      hold_d      = in_if.data;
      hold_last_d = in_if.last;
      hold_full_d = 1'b1;
      last_seen_d = last_seen_d | in_if.last;
    end

    ready_d  = !hold_full_d && !last_seen_d && (state_d != GUARD) && !done_d;
    busy_d   = (state_d != IDLE);
    enable_d = (state_d == PREAMBLE) || (state_d == SYNC) || (state_d == PAYLOAD);

    case (state_d)
      PREAMBLE: value_d = idx_d[0] ? PREAMBLE_LO : PREAMBLE_HI;
      SYNC:     value_d = sync_symbol(SYNC_WORD, idx_d[2:0]);
      PAYLOAD:  value_d = shift_d[7:6];
      default:  value_d = 2'd0;
    endcase
  end

  assign in_if.ready = ready_q;
  assign value_o     = value_q;
  assign enable_o    = enable_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign underrun_o  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_symbol_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_symbol_framer : directed + random frames against a symbol-list model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_symbol_framer;

  localparam int          PRE  = 4;
  localparam int          GRD  = 2;
  localparam int          SC   = 4;
  localparam logic [15:0] SW   = 16'hD391;
  localparam int          DPRE = 16;
  localparam int          DGRD = 4;
  localparam int          DSC  = 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  symbol_framer_if bus ();
  symbol_framer_if bus_d ();

  logic [1:0] val, d_val;
  logic       en, bsy, dn, ur, d_en, d_bsy, d_dn, d_ur;

  symbol_framer #(
    .CLOCK_FREQUENCY (16),
    .SYMBOL_RATE     (4),
    .PREAMBLE_SYMBOLS(PRE),
    .SYNC_WORD       (SW),
    .GUARD_SYMBOLS   (GRD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_if(bus.slave),
    .value_o(val), .enable_o(en), .busy_o(bsy), .done_o(dn), .underrun_o(ur)
  );

  symbol_framer dut_def (
    .clk(clk), .rst_n(rst_n), .in_if(bus_d.slave),
    .value_o(d_val), .enable_o(d_en), .busy_o(d_bsy), .done_o(d_dn), .underrun_o(d_ur)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] fb [0:15];
  logic [2:0] exp_sym [$];   // {enable, value} per symbol period

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of symbols: preamble, sync word, payload bytes, guard.
  task automatic build_model(input int n, input int pre, input int grd);
    exp_sym.delete();
    for (int i = 0; i < pre; i++) exp_sym.push_back({1'b1, (i % 2 == 0) ? 2'd3 : 2'd0});
    for (int i = 0; i < 8; i++) exp_sym.push_back({1'b1, 2'((SW >> (14 - 2 * i)) & 16'h3)});
    for (int b = 0; b < n; b++)
      for (int i = 0; i < 4; i++) exp_sym.push_back({1'b1, 2'((fb[b] >> (6 - 2 * i)) & 8'h3)});
    for (int i = 0; i < grd; i++) exp_sym.push_back(3'b000);
  endtask

  task automatic run_frame(input int n, input bit with_last, input bit next_in_guard,
                           input logic [7:0] next_byte, input bit pre_accepted,
                           input int abort_k, input string tag);
    int acc, nsym, gstart, urun_k, w;
    bit next_taken;
    logic [5:0] exp_v;
    build_model(n, PRE, GRD);
    nsym       = exp_sym.size();
    gstart     = SC * (nsym - GRD);
    urun_k     = with_last ? -1 : gstart;
    next_taken = 1'b0;
    acc        = pre_accepted ? 1 : 0;
    if (!pre_accepted) begin
      @(negedge clk);
      bus.valid = 1'b1; bus.data = fb[0]; bus.last = with_last && (n == 1);
      w = 0;
      while (bus.ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      check({tag, "_start_ready"}, 32'(bus.ready), 32'd1);
      acc = 1;
    end
    for (int k = 0; k <= SC * nsym + 1; k++) begin
      @(negedge clk);
      if (k < SC * nsym)       exp_v = {1'b1, exp_sym[k / SC], 1'b0, (k == urun_k)};
      else if (k == SC * nsym) exp_v = 6'b000010;
      else                     exp_v = 6'b000000;
      check({tag, "_busy_en_val_done_urun"}, 32'({bsy, en, val, dn, ur}), 32'(exp_v));
      if (k < SC * (PRE + 8) || (k >= gstart && k <= SC * nsym))
        check({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
      if (k == SC * nsym + 1)
        check({tag, "_ready_after_done"}, 32'(bus.ready), 32'd1);
      if (k == abort_k) return;
      if (acc < n) begin
        bus.valid = 1'b1; bus.data = fb[acc]; bus.last = with_last && (acc == n - 1);
        if (bus.ready) acc++;
      end else if (next_in_guard && k >= gstart) begin
        bus.valid = 1'b1; bus.data = next_byte; bus.last = 1'b1;
        if (bus.ready) next_taken = 1'b1;
      end else begin
        bus.valid = 1'b0; bus.data = 8'($urandom); bus.last = 1'($urandom);
      end
    end
    check({tag, "_bytes_accepted"}, 32'(acc), 32'(n));
    if (next_in_guard) check({tag, "_next_taken"}, 32'(next_taken), 32'd1);
  endtask

  task automatic run_default(input logic [7:0] b);
    int nsym, en_cnt, done_k;
    fb[0] = b;
    build_model(1, DPRE, DGRD);
    nsym = exp_sym.size();
    @(negedge clk);
    bus_d.valid = 1'b1; bus_d.data = b; bus_d.last = 1'b1;
    check("def_start_ready", 32'(bus_d.ready), 32'd1);
    en_cnt = 0;
    done_k = -1;
    for (int k = 0; k <= DSC * nsym + 1; k++) begin
      @(negedge clk);
      bus_d.valid = 1'b0;
      if (k < DSC * nsym) check("def_symbol", 32'({d_en, d_val}), 32'(exp_sym[k / DSC]));
      if (d_en) en_cnt++;
      if (d_dn && done_k < 0) done_k = k;
    end
    check("def_enable_clocks", 32'(en_cnt), 32'((DPRE + 8 + 4) * DSC));
    check("def_done_clock", 32'(done_k), 32'(DSC * nsym));
  endtask

  initial begin
    int n, dcount;
    bit wl;
    rst_n = 1'b0;
    bus.valid = 1'b0;   bus.data = 8'h00;   bus.last = 1'b0;
    bus_d.valid = 1'b0; bus_d.data = 8'h00; bus_d.last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bsy, en, val, dn, ur}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd1);

    fb[0] = 8'hB4;
    run_frame(1, 1'b1, 1'b0, 8'h00, 1'b0, -1, "single_b4");

    fb[0] = 8'h00; fb[1] = 8'hFF;
    run_frame(2, 1'b1, 1'b0, 8'h00, 1'b0, -1, "back2back");

    fb[0] = 8'h12;
    run_frame(1, 1'b0, 1'b0, 8'h00, 1'b0, -1, "underrun");

    fb[0] = 8'h5A;
    run_frame(1, 1'b1, 1'b1, 8'hA7, 1'b0, -1, "guard_valid");
    fb[0] = 8'hA7;
    run_frame(1, 1'b1, 1'b0, 8'h00, 1'b1, -1, "guard_next");

    fb[0] = 8'h3C;
    run_frame(1, 1'b1, 1'b0, 8'h00, 1'b0, SC * PRE + 5, "mid_sync");
    #1 rst_n = 1'b0;
    #1 check("rst_async_outputs", 32'({bsy, en, val}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(bus.ready), 32'd1);
    dcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dn || bsy) dcount++;
    end
    check("rst_no_done", 32'(dcount), 32'd0);

    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, 3);
      wl = 1'($urandom_range(0, 1));
      for (int b = 0; b < n; b++) fb[b] = 8'($urandom);
      run_frame(n, wl, 1'b0, 8'h00, 1'b0, -1, "random");
    end

    run_default(8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
